// File: rtl/uart_rx_os_fifo.sv
// Oversampling UART receiver (3-sample majority vote) feeding a FWFT receive FIFO; parity via UART_RX_PARITY_EN.
// Byte lands in the FIFO one clk after the final stop-bit vote; a full FIFO drops the frame and pulses overrun.
module uart_rx_os_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   input  logic                          parity_odd,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_empty,
   output logic                          rd_full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun
);

   localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SCW = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
   localparam logic [SCW-1:0] SC_LAST   = SCW'(OVERSAMPLE - 1);
   localparam logic [SCW-1:0] SC_S0     = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] SC_S1     = SCW'(OVERSAMPLE / 2);
   localparam logic [SCW-1:0] SC_VOTE   = SCW'(OVERSAMPLE / 2 + 1);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               state;
   logic                 rx_s1, rx_s2, rx_prev;
   logic                 fall;
   logic [CW-1:0]        div_cnt;
   logic                 tick;
   logic [SCW-1:0]       sc;
   logic                 smp0, smp1;
   logic                 vote;
   logic                 at_vote, at_end;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic                 stop_bad;
   logic [DATA_BITS-1:0] data;
   logic                 final_vote;
   logic                 frame_good;
   logic                 push, pop;
   logic [AW:0]          wr_ptr, rd_ptr;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // A held-low line after a bad stop bit produces no edge until it returns high.
   assign fall = rx_prev & ~rx_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_cnt <= '0;
      else if ((state == S_IDLE && fall) || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick    = (div_cnt == DIV_LAST);
   assign vote    = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
   assign at_vote = tick && (sc == SC_VOTE);
   assign at_end  = tick && (sc == SC_LAST);

   assign final_vote = at_vote && (state == S_STOP) && (stop_idx == STOP_LAST);

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   assign frame_good = vote & ~stop_bad & ~par_bad;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
   assign frame_good = vote & ~stop_bad;
`endif

   assign pop  = rd_en & ~rd_empty;
   assign push = final_vote & frame_good & (~rd_full | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sc         <= '0;
         smp0       <= 1'b0;
         smp1       <= 1'b0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         stop_bad   <= 1'b0;
         data       <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
`endif
      end else begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
         if (state != S_IDLE && tick) begin
            if (sc == SC_S0) smp0 <= rx_s2;
            if (sc == SC_S1) smp1 <= rx_s2;
            sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (fall) begin
                  state    <= S_START;
                  sc       <= '0;
                  stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  par_bad  <= 1'b0;
`endif
               end
            end
            S_START: begin
               if (at_vote && vote) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (at_end) begin
                  state   <= S_DATA;
                  bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (at_vote)
                  data[bit_idx] <= vote;
               if (at_end) begin
                  if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                     stop_idx <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (at_vote)
                  par_bad <= vote ^ (^data) ^ parity_odd;
               if (at_end)
                  state <= S_STOP;
            end
`endif
            S_STOP: begin
               // Resolve at the final vote so the next start edge is never missed.
               if (final_vote) begin
                  if (!vote || stop_bad)
                     frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  else if (par_bad)
                     parity_err <= 1'b1;
`endif
                  else if (!push)
                     overrun <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  if (at_vote)
                     stop_bad <= stop_bad | ~vote;
                  if (at_end)
                     stop_idx <= stop_idx + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rd_data  = mem[rd_ptr[AW-1:0]];
   assign level    = wr_ptr - rd_ptr;
   assign rd_empty = (wr_ptr == rd_ptr);
   assign rd_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: tb/tb_uart_rx_os_fifo.sv
// Bench for uart_rx_os_fifo at 16 MHz / 1 Mbaud / x16 with a 4-entry FIFO; scoreboard for bytes and error pulses.
module tb_uart_rx_os_fifo;

   localparam int DB      = 8;
   localparam int DEPTH   = 4;
`ifdef UART_RX_PARITY_EN
   localparam int PB      = 1;
`else
   localparam int PB      = 0;
`endif
   localparam int NB      = 1 + DB + PB + 1;
   localparam int VOTE_C  = 13 + 16 * (NB - 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx;
   logic          parity_odd;
   logic          rd_en;
   logic [DB-1:0] rd_data;
   logic          rd_empty;
   logic          rd_full;
   logic [2:0]    level;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    exp_data[$];
   logic [2:0]    exp_err[$];

   localparam logic [2:0] E_FRAME = 3'b100;
   localparam logic [2:0] E_PAR   = 3'b010;
   localparam logic [2:0] E_OVR   = 3'b001;

   uart_rx_os_fifo #(
      .CLK_FREQ   (16_000_000),
      .BAUD_RATE  (1_000_000),
      .OVERSAMPLE (16),
      .DATA_BITS  (DB),
      .STOP_BITS  (1),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .parity_odd (parity_odd),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_empty   (rd_empty),
      .rd_full    (rd_full),
      .level      (level),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted read and every error pulse.
   always @(negedge clk) begin
      logic [7:0] e;
      logic [2:0] k;
      if (rst_n && rd_en && !rd_empty) begin
         n_checks++;
         if (exp_data.size() == 0) begin
            n_fail++;
            $display("FAIL rd_data: unexpected pop 0x%0h, none expected", rd_data);
         end else begin
            e = exp_data.pop_front();
            if (rd_data != e) begin
               n_fail++;
               $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, e);
            end
         end
      end
      if (frame_err || parity_err || overrun) begin
         n_checks++;
         if (exp_err.size() == 0) begin
            n_fail++;
            $display("FAIL err_pulse: got {frame,parity,ovr}=%b, none expected", {frame_err, parity_err, overrun});
         end else begin
            k = exp_err.pop_front();
            if ({frame_err, parity_err, overrun} != k) begin
               n_fail++;
               $display("FAIL err_pulse: got {frame,parity,ovr}=%b, expected %b", {frame_err, parity_err, overrun}, k);
            end
         end
      end
   end

   task automatic tick_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick_wait();
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      tick_wait();
      rd_en = 1'b0;
   endtask

   // One frame, 16 clk per bit; optional parity flip, stop value, 1-sample glitch, timing probe, mid-frame reset.
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_val,
                             input int glitch_bit, input bit chk, input int abort_c);
      logic [15:0] bits;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DB; i++) bits[1+i] = d[i];
      if (PB == 1) bits[1+DB] = (^d) ^ parity_odd ^ par_flip;
      bits[NB-1] = stop_val;
      for (int c = 0; c < NB * 16; c++) begin
         if (c == abort_c) begin
            rst_n = 1'b0;
            return;
         end
         rx = (c / 16 == glitch_bit && c % 16 == 9) ? 1'b0 : bits[c/16];
         if (chk && c == VOTE_C - 1) check("level_before_vote", int'(level), 0);
         if (chk && c == VOTE_C) begin
            check("level_after_vote", int'(level), 1);
            check("head_after_vote", int'(rd_data), int'(d));
         end
         tick_wait();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rx = 1'b1;
      rd_en = 1'b0;
      parity_odd = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick_wait();
      check("rst_empty", int'(rd_empty), 1);
      check("rst_full", int'(rd_full), 0);
      check("rst_level", int'(level), 0);
      check("rst_err", int'({frame_err, parity_err, overrun}), 0);
      rst_n = 1'b1;
      idle(5);

      // Plain frame with cycle-exact push check.
      exp_data.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b1, -1);
      idle(4);
      pop1();
      check("a5_empty_after_pop", int'(rd_empty), 1);
      check("a5_level_after_pop", int'(level), 0);

      // Glitch on data bit 2 (frame bit 3) is outvoted.
      exp_data.push_back(8'h3C);
      send_frame(8'h3C, 1'b0, 1'b1, 3, 1'b0, -1);
      idle(4);
      check("3c_level", int'(level), 1);
      pop1();
      check("3c_empty", int'(rd_empty), 1);

      // Bad stop bit, line held low, then recovery.
      exp_err.push_back(E_FRAME);
      send_frame(8'h55, 1'b0, 1'b0, -1, 1'b0, -1);
      rx = 1'b0;
      repeat (20) tick_wait();
      check("55_level", int'(level), 0);
      check("55_empty", int'(rd_empty), 1);
      idle(20);
      exp_data.push_back(8'h12);
      send_frame(8'h12, 1'b0, 1'b1, -1, 1'b0, -1);
      idle(4);
      check("12_level", int'(level), 1);
      pop1();

`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
      exp_err.push_back(E_PAR);
      send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0, -1);
      idle(4);
      check("par_bad_level", int'(level), 0);
      exp_data.push_back(8'h07);
      send_frame(8'h07, 1'b0, 1'b1, -1, 1'b0, -1);
      idle(4);
      check("par_ok_level", int'(level), 1);
      pop1();
`endif

      // Five back-to-back frames into a 4-deep FIFO.
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_data.push_back(8'(i));
         else        exp_err.push_back(E_OVR);
         send_frame(8'(i), 1'b0, 1'b1, -1, 1'b0, -1);
         if (i == 3) check("ovr_full_after_3", int'(rd_full), 0);
         if (i == 4) check("ovr_full_after_4", int'(rd_full), 1);
      end
      idle(4);
      check("ovr_level", int'(level), 4);
      check("ovr_full", int'(rd_full), 1);
      rd_en = 1'b1;
      repeat (4) tick_wait();
      rd_en = 1'b0;
      check("ovr_drained", int'(rd_empty), 1);

      // Reset mid-frame with two bytes queued.
      send_frame(8'h21, 1'b0, 1'b1, -1, 1'b0, -1);
      send_frame(8'h42, 1'b0, 1'b1, -1, 1'b0, -1);
      idle(4);
      check("pre_rst_level", int'(level), 2);
      send_frame(8'h99, 1'b0, 1'b1, -1, 1'b0, 16 * 4 + 5);
      rx = 1'b1;
      repeat (3) tick_wait();
      rst_n = 1'b1;
      tick_wait();
      check("post_rst_level", int'(level), 0);
      check("post_rst_empty", int'(rd_empty), 1);
      idle(20);
      exp_data.push_back(8'h6B);
      send_frame(8'h6B, 1'b0, 1'b1, -1, 1'b0, -1);
      idle(4);
      check("6b_level", int'(level), 1);
      pop1();

      idle(10);
      check("data_queue_drained", exp_data.size(), 0);
      check("err_queue_drained", exp_err.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
